// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store controller between execute stage and data memory.
// Latency: 2+ cycles accept-to-resp_valid for memory ops, 1 cycle for rejected ops.
// Backpressure: req_ready only in IDLE; mem_req held until mem_ack. Option macro: LSU_TIMEOUT_EN.
module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] ld_data,
  output logic        resp_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] ld_q, ld_d;
  logic        err_q, err_d;

  logic        illegal, misalign;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_ext;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

`ifdef LSU_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  // Classify the incoming request: unsupported width code or unaligned address.
  always_comb begin
    illegal  = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (is_store && funct3[2]);
    misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
               ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
  end

  // Pick the addressed byte/half from the returned word and extend it.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ld_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  ld_ext = {24'd0, byte_sel};
      3'b101:  ld_ext = {16'd0, half_sel};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Replicate store data across lanes and enable only the addressed bytes.
  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        st_be    = 4'b0001 << addr_q[1:0];
        st_wdata = {4{sdata_q[7:0]}};
      end
      2'b01: begin
        st_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{sdata_q[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = sdata_q;
      end
    endcase
  end

  // State and request/response registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      f3_q       <= 3'd0;
      addr_q     <= 32'd0;
      sdata_q    <= 32'd0;
      ld_q       <= 32'd0;
      err_q      <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q      <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      f3_q       <= f3_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      ld_q       <= ld_d;
      err_q      <= err_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Next-state: accept in IDLE, wait for ack (or watchdog) in WAIT, one-cycle RESP.
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    ld_d       = ld_q;
    err_d      = err_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          is_store_d = is_store;
          f3_d       = funct3;
          addr_d     = addr;
          sdata_d    = store_data;
          ld_d       = 32'd0;
          err_d      = illegal || misalign;
          state_d    = (illegal || misalign) ? S_RESP : S_WAIT;
`ifdef LSU_TIMEOUT_EN
          cnt_d      = 32'd0;
`endif
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          ld_d    = is_store_q ? 32'd0 : ld_ext;
          err_d   = 1'b0;
          state_d = S_RESP;
`ifdef LSU_TIMEOUT_EN
        end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          ld_d    = 32'd0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q + 32'd1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from state so they are quiet outside WAIT/RESP and stable during WAIT.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    mem_req    = (state_q == S_WAIT);
    mem_we     = mem_req && is_store_q;
    mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_be     = mem_req ? (is_store_q ? st_be : 4'b1111) : 4'd0;
    mem_wdata  = (mem_req && is_store_q) ? st_wdata : 32'd0;
    resp_valid = (state_q == S_RESP);
    resp_err   = resp_valid && err_q;
    ld_data    = resp_valid ? ld_q : 32'd0;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed cases plus randomized requests against a behavioural model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] ld_data;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

`ifdef LSU_TIMEOUT_EN
  localparam int MAXD = 2;
`else
  localparam int MAXD = 7;
`endif

  lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .funct3(funct3), .addr(addr), .store_data(store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .ld_data(ld_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model: access size in bytes, then plain arithmetic ----
  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic m_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (st && f3 > 3'd2) return 1'b1;
    return (a % acc_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (!st) return 4'hF;
    sz = acc_size(f3);
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (acc_size(f3))
      1:       return (sd & 32'hFF) * 32'h01010101;
      2:       return (sd & 32'hFFFF) * 32'h00010001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] m_ld(input logic st, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] rd);
    int sz;
    logic [31:0] mask, v;
    if (st) return 32'd0;
    sz = acc_size(f3);
    if (sz == 4) return rd;
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v = (rd >> (8 * (a % 4))) & mask;
    if (f3 < 3'd4 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // One complete request: accept, optional WAIT with ack after dly cycles, RESP, back to IDLE.
  task automatic do_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int dly);
    logic e;
    e = m_err(st, f3, a);
    @(negedge clk);
    check("ready_before_accept", req_ready, 1'b1);
    req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (e) begin
      check("err_resp_valid", resp_valid, 1'b1);
      check("err_resp_err", resp_err, 1'b1);
      check("err_ld_zero", ld_data, 32'd0);
      check("err_no_mem_req", mem_req, 1'b0);
      mem_ack = 1'($urandom);
    end else begin
      for (int k = 0; k <= dly; k++) begin
        check("wait_mem_req", mem_req, 1'b1);
        check("wait_no_resp", resp_valid, 1'b0);
        check("wait_no_ready", req_ready, 1'b0);
        check("wait_mem_addr", mem_addr, a & 32'hFFFF_FFFC);
        check("wait_mem_we", mem_we, st);
        check("wait_mem_be", mem_be, m_be(st, f3, a));
        if (st) check("wait_mem_wdata", mem_wdata, m_wdata(f3, sd));
        if (k == dly) begin
          mem_ack = 1'b1; mem_rdata = rd; req_valid = 1'b0;
        end else begin
          mem_ack = 1'b0; mem_rdata = $urandom;
          req_valid = 1'($urandom); addr = $urandom; store_data = $urandom;
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
      end
      check("resp_valid", resp_valid, 1'b1);
      check("resp_err_clear", resp_err, 1'b0);
      check("resp_ld_data", ld_data, m_ld(st, f3, a, rd));
      check("resp_mem_req_low", mem_req, 1'b0);
      mem_ack = 1'($urandom);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("resp_one_cycle", resp_valid, 1'b0);
    check("back_to_idle", req_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0;
    store_data = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_be", mem_be, 4'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_ld_data", ld_data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1 check("rel_req_ready", req_ready, 1'b1);

    // LB sign-extend, ack in first WAIT cycle
    do_txn(1'b0, 3'b000, 32'h1003, 32'd0, 32'h8000_0000, 0);
    // LHU upper half zero-extend
    do_txn(1'b0, 3'b101, 32'h2002, 32'd0, 32'hBEEF_1234, 1);
    // SB lane 1
    do_txn(1'b1, 3'b000, 32'h11, 32'hAB, 32'd0, 0);
    // misaligned LW rejected without memory access
    do_txn(1'b0, 3'b010, 32'h6, 32'd0, 32'd0, 0);
    // illegal: store with unsigned width, and reserved code
    do_txn(1'b1, 3'b100, 32'h100, 32'h1234, 32'd0, 0);
    do_txn(1'b0, 3'b111, 32'h100, 32'd0, 32'd0, 0);
    // SH upper half, LH sign-extend, SW
    do_txn(1'b1, 3'b001, 32'h22, 32'h5566_CAFE, 32'd0, 2);
    do_txn(1'b0, 3'b001, 32'h30, 32'd0, 32'h0000_9ABC, 0);
    do_txn(1'b1, 3'b010, 32'h44, 32'hDEAD_BEEF, 32'd0, 3);

    // reset during WAIT abandons the store
    @(negedge clk);
    req_valid = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h40; store_data = $urandom;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstwait_req_before", mem_req, 1'b1);
    rst = 1'b1;
    #1;
    check("rstwait_mem_req", mem_req, 1'b0);
    check("rstwait_mem_be", mem_be, 4'd0);
    check("rstwait_resp", resp_valid, 1'b0);
    @(negedge clk); rst = 1'b0;
    for (int c = 4; c <= 8; c++) begin
      @(posedge clk); #1;
      mem_ack = (c == 5);
      check("rstwait_no_resp", resp_valid, 1'b0);
      check("rstwait_no_req", mem_req, 1'b0);
      check("rstwait_ready", req_ready, 1'b1);
    end
    mem_ack = 1'b0;

`ifdef LSU_TIMEOUT_EN
    // watchdog: no ack for 4 WAIT cycles
    @(negedge clk);
    req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h80;
    @(posedge clk); #1 req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("to_wait_req", mem_req, 1'b1);
      check("to_wait_no_resp", resp_valid, 1'b0);
      @(posedge clk); #1;
    end
    check("to_resp_valid", resp_valid, 1'b1);
    check("to_resp_err", resp_err, 1'b1);
    check("to_ld_zero", ld_data, 32'd0);
    check("to_req_low", mem_req, 1'b0);
    @(posedge clk); #1;
    check("to_idle", req_ready, 1'b1);
`else
    // without watchdog, WAIT outlasts any bound
    do_txn(1'b0, 3'b100, 32'h0000_0F01, 32'd0, 32'h1122_8344, 20);
`endif

    // randomized requests
    for (int n = 0; n < 60; n++) begin
      logic [31:0] ra;
      ra = $urandom;
      do_txn(1'($urandom), 3'($urandom), ra, $urandom, $urandom,
             int'($urandom_range(MAXD, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, maximum mem_ack wait in cycles; used only when LSU_TIMEOUT_EN is defined.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req_valid  input  1  execute stage presents a memory operation.
REQ-005 req_ready  output  1  lsu can accept a request.
REQ-006 is_store  input  1  1 = store, 0 = load.
REQ-007 funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr  input  32  effective address, taken directly from ALU alu_data.
REQ-009 store_data  input  32  rs2 value for stores.
REQ-010 mem_req  output  1  data-memory request, held until mem_ack.
REQ-011 mem_we  output  1  memory write enable.
REQ-012 mem_addr  output  32  word address: {addr[31:2],2'b00}.
REQ-013 mem_wdata  output  32  lane-aligned store data.
REQ-014 mem_be  output  4  byte enables.
REQ-015 mem_ack  input  1  memory completes the access this cycle.
REQ-016 mem_rdata  input  32  read word, valid when mem_ack=1.
REQ-017 resp_valid  output  1  one-cycle completion pulse.
REQ-018 ld_data  output  32  extended load result, valid with resp_valid.
REQ-019 resp_err  output  1  misaligned, illegal funct3 or timeout; valid with resp_valid.

Function
REQ-020 FSM states: IDLE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-021 IDLE: on req_valid=1, latch all request inputs; legal and aligned -> WAIT with mem_req=1 from next cycle; otherwise -> RESP with resp_err=1 and no memory access.
REQ-022 Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0. Illegal: funct3 011/110/111, or store with funct3[2]=1.
REQ-023 WAIT: mem_req, mem_we, mem_addr, mem_wdata, mem_be held stable; mem_ack in the same cycle mem_req first rises is valid; on mem_ack, capture mem_rdata, drop mem_req next cycle, go RESP.
REQ-024 RESP: resp_valid=1 for exactly one cycle, then IDLE; minimum accept-to-resp_valid latency is 2 cycles; error path latency is 1 cycle.
REQ-025 Store lanes: SB: be=0001<<addr[1:0], wdata=4 copies of store_data[7:0]; SH: be=0011 (addr[1]=0) or 1100, wdata=2 copies of store_data[15:0]; SW: be=1111, wdata=store_data.
REQ-026 Loads: mem_we=0, mem_be=1111; select byte/half by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-027 ld_data=0 for stores and for error responses.
REQ-028 mem_ack outside WAIT is ignored; req_valid outside IDLE is ignored (not accepted).

Reset
REQ-029 rst=1 forces IDLE immediately: mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_err=0, ld_data=0, req_ready=1 after release.
REQ-030 Reset during WAIT abandons the access; no resp_valid is produced for it.

Configuration
REQ-031 Macro LSU_TIMEOUT_EN defined: counter starts at 0 on WAIT entry; if no mem_ack after TIMEOUT_CYCLES cycles, drop mem_req and go RESP with resp_err=1, ld_data=0.
REQ-032 LSU_TIMEOUT_EN undefined: no counter; WAIT persists until mem_ack or reset.

Verification
REQ-033 LB: addr=0x1003, mem_rdata=0x80_00_00_00, ack 1st cycle -> mem_addr=0x1000, ld_data=0xFFFFFF80, resp_valid at cycle 2.
REQ-034 LHU: addr=0x2002, mem_rdata=0xBEEF1234 -> ld_data=0x0000BEEF, resp_err=0.
REQ-035 SB: addr=0x11, store_data=0xAB -> mem_be=0010, mem_wdata=0xABABABAB, mem_we=1.
REQ-036 LW: addr=0x6 -> resp_err=1 at cycle 1, mem_req never asserted.
REQ-037 SW: addr=0x40, mem_ack delayed 5 cycles, rst pulsed in cycle 3 -> mem_req=0 immediately, no resp_valid, req_ready=1.
REQ-038 LSU_TIMEOUT_EN defined with TIMEOUT_CYCLES=4, mem_ack never asserted -> resp_valid with resp_err=1 after 4 WAIT cycles.
